// File: rtl/matrix_pkg.sv
// Shared types and helpers for the 8x8 LED matrix scan driver and its frame store.
package matrix_pkg;

    localparam int MATRIX_ROWS = 8;
    localparam int MATRIX_COLS = 8;
    localparam int ROW_IDX_W   = 3;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    // Converts a logical bitmap (1 = active) into pin levels for the given polarity.
    function automatic logic [MATRIX_COLS-1:0] map_level(
        input logic [MATRIX_COLS-1:0] bits,
        input logic                   active_high
    );
        return active_high ? bits : ~bits;
    endfunction

endpackage

// File: rtl/matrix_frame_buffer.sv
// Double-buffered 8x8 frame store: writers fill the back bank while the scanner
// reads the front bank; a swap pulse exchanges the roles without copying data.
module matrix_frame_buffer
    import matrix_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [ROW_IDX_W-1:0]   wr_row,
    input  logic [MATRIX_COLS-1:0] wr_data,
    input  logic                   swap,
    input  logic [ROW_IDX_W-1:0]   rd_row,
    output logic [MATRIX_COLS-1:0] rd_data
);

    logic                   front_bank;
    logic [MATRIX_COLS-1:0] bank [2][MATRIX_ROWS];

    // Bank storage and front-bank select; the front bank is never written.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            front_bank <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < MATRIX_ROWS; r++) begin
                    bank[b][r] <= '0;
                end
            end
        end else begin
            if (wr_en) begin
                bank[~front_bank][wr_row] <= wr_data;
            end
            if (swap) begin
                front_bank <= ~front_bank;
            end
        end
    end

    assign rd_data = bank[front_bank][rd_row];

endmodule

// File: rtl/led_matrix_scan_driver.sv
// Row-multiplexed 8x8 LED matrix driver: blanks, then lights each row in turn from
// the front bank, and swaps banks only at the end of row 7 so frames never tear.
module led_matrix_scan_driver
    import matrix_pkg::*;
#(
    parameter int ROW_DWELL_CYCLES = 2000,
    parameter int BLANK_CYCLES     = 16,
    parameter int ROW_ACTIVE_HIGH  = 1,
    parameter int COL_ACTIVE_LOW   = 1
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [ROW_IDX_W-1:0]   wr_row,
    input  logic [MATRIX_COLS-1:0] wr_data,
    input  logic                   commit,
    output logic                   commit_pending,
    output logic                   frame_start,
    output logic [MATRIX_ROWS-1:0] ROW,
    output logic [MATRIX_COLS-1:0] COL
);

    // The counter runs 1..N inside each state; the reset value 0 is a one-off
    // prelude so the first cycle after reset release is BLANK cycle 1 of row 0.
    localparam int CNT_MAX = (ROW_DWELL_CYCLES > BLANK_CYCLES) ? ROW_DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]       CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]       BLANK_LAST = CNT_W'(BLANK_CYCLES);
    localparam logic [CNT_W-1:0]       DRIVE_LAST = CNT_W'(ROW_DWELL_CYCLES);
    localparam logic [ROW_IDX_W-1:0]   LAST_ROW   = ROW_IDX_W'(MATRIX_ROWS - 1);
    localparam logic [MATRIX_ROWS-1:0] ROW_FIRST  = 8'h80;
    localparam logic                   ROW_HIGH   = (ROW_ACTIVE_HIGH != 0);
    localparam logic                   COL_HIGH   = (COL_ACTIVE_LOW == 0);
    localparam logic [MATRIX_ROWS-1:0] ROW_OFF    = ROW_HIGH ? 8'h00 : 8'hFF;
    localparam logic [MATRIX_COLS-1:0] COL_OFF    = COL_HIGH ? 8'h00 : 8'hFF;

    scan_state_t            state, next_state;
    logic [CNT_W-1:0]       cnt, next_cnt;
    logic [ROW_IDX_W-1:0]   row_idx, next_row;
    logic [MATRIX_ROWS-1:0] next_row_pins;
    logic [MATRIX_COLS-1:0] next_col_pins;
    logic [MATRIX_COLS-1:0] front_data;
    logic                   next_pending, next_ready, next_frame_start;
    logic                   swap, wr_en;

    assign wr_en = wr_valid && wr_ready;

    matrix_frame_buffer u_frame_buffer (
        .clk     (CLK),
        .rst_n   (RST_N),
        .wr_en   (wr_en),
        .wr_row  (wr_row),
        .wr_data (wr_data),
        .swap    (swap),
        .rd_row  (row_idx),
        .rd_data (front_data)
    );

    // Next-state logic: scan sequencing, pin values, commit/swap handshake and frame marker.
    always_comb begin
        next_state    = state;
        next_cnt      = cnt + CNT_ONE;
        next_row      = row_idx;
        next_row_pins = ROW;
        next_col_pins = COL;
        swap          = 1'b0;

        case (state)
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    next_state    = DRIVE;
                    next_cnt      = CNT_ONE;
                    next_row_pins = map_level(ROW_FIRST >> row_idx, ROW_HIGH);
                    next_col_pins = map_level(front_data, COL_HIGH);
                end
            end
            DRIVE: begin
                if (cnt == DRIVE_LAST) begin
                    next_state    = BLANK;
                    next_cnt      = CNT_ONE;
                    next_row      = row_idx + ROW_IDX_W'(1);
                    next_row_pins = ROW_OFF;
                    next_col_pins = COL_OFF;
                    swap          = (row_idx == LAST_ROW) && commit_pending;
                end
            end
        endcase

        next_pending = commit_pending;
        next_ready   = wr_ready;
        if (swap) begin
            next_pending = 1'b0;
            next_ready   = 1'b1;
        end else if (commit && !commit_pending) begin
            next_pending = 1'b1;
            next_ready   = 1'b0;
        end

        next_frame_start = (next_state == BLANK) && (next_cnt == CNT_ONE) && (next_row == '0);
    end

    // State, counters and registered pin/handshake outputs.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state          <= BLANK;
            cnt            <= '0;
            row_idx        <= '0;
            ROW            <= ROW_OFF;
            COL            <= COL_OFF;
            commit_pending <= 1'b0;
            wr_ready       <= 1'b1;
            frame_start    <= 1'b0;
        end else begin
            state          <= next_state;
            cnt            <= next_cnt;
            row_idx        <= next_row;
            ROW            <= next_row_pins;
            COL            <= next_col_pins;
            commit_pending <= next_pending;
            wr_ready       <= next_ready;
            frame_start    <= next_frame_start;
        end
    end

endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// Directed bench for led_matrix_scan_driver with BLANK_CYCLES=2, ROW_DWELL_CYCLES=4
// (48-cycle frame; row r is BLANK at frame cycles 6r..6r+1 and DRIVE at 6r+2..6r+5).
module tb_led_matrix_scan_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic       rst_n, wr_valid, commit, wr_ready, commit_pending, frame_start;
    logic [2:0] wr_row;
    logic [7:0] wr_data, row_pins, col_pins;

    logic       p_rst_n, p_wr_valid, p_commit, p_wr_ready, p_commit_pending, p_frame_start;
    logic [2:0] p_wr_row;
    logic [7:0] p_wr_data, p_row_pins, p_col_pins;

    led_matrix_scan_driver #(
        .ROW_DWELL_CYCLES(4), .BLANK_CYCLES(2), .ROW_ACTIVE_HIGH(1), .COL_ACTIVE_LOW(1)
    ) dut (
        .CLK(clk), .RST_N(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_row(wr_row), .wr_data(wr_data), .commit(commit),
        .commit_pending(commit_pending), .frame_start(frame_start),
        .ROW(row_pins), .COL(col_pins)
    );

    led_matrix_scan_driver #(
        .ROW_DWELL_CYCLES(4), .BLANK_CYCLES(2), .ROW_ACTIVE_HIGH(0), .COL_ACTIVE_LOW(0)
    ) dut_pol (
        .CLK(clk), .RST_N(p_rst_n), .wr_valid(p_wr_valid), .wr_ready(p_wr_ready),
        .wr_row(p_wr_row), .wr_data(p_wr_data), .commit(p_commit),
        .commit_pending(p_commit_pending), .frame_start(p_frame_start),
        .ROW(p_row_pins), .COL(p_col_pins)
    );

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic goto_cycle(input int target);
        while (cyc < target) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_valid = 1'b0; commit = 1'b0; wr_row = 3'd0; wr_data = 8'h00;
        p_rst_n = 1'b0; p_wr_valid = 1'b0; p_commit = 1'b0; p_wr_row = 3'd0; p_wr_data = 8'h00;
        repeat (3) tick();
        vectors++; if (row_pins !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_row got %h expected %h", row_pins, 8'h00); end
        vectors++; if (col_pins !== 8'hFF) begin miscompares++; $display("[TB] FAIL reset_col got %h expected %h", col_pins, 8'hFF); end
        vectors++; if (frame_start !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_frame_start got %b expected 0", frame_start); end
        vectors++; if (commit_pending !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_pending got %b expected 0", commit_pending); end
        vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_wr_ready got %b expected 1", wr_ready); end
        rst_n = 1'b1;
        cyc = -1;
        tick();
    endtask

    task automatic test_scan_timing();
        logic [7:0] er;
        for (int c = 0; c < 48; c++) begin
            er = ((c % 6) < 2) ? 8'h00 : (8'h80 >> (c / 6));
            vectors++; if (row_pins !== er) begin miscompares++; $display("[TB] FAIL scan_row c=%0d got %h expected %h", c, row_pins, er); end
            vectors++; if (col_pins !== 8'hFF) begin miscompares++; $display("[TB] FAIL scan_col c=%0d got %h expected %h", c, col_pins, 8'hFF); end
            vectors++; if (frame_start !== (c == 0)) begin miscompares++; $display("[TB] FAIL scan_frame_start c=%0d got %b expected %b", c, frame_start, (c == 0)); end
            tick();
        end
        vectors++; if (frame_start !== 1'b1) begin miscompares++; $display("[TB] FAIL frame_period got %b expected 1", frame_start); end
    endtask

    task automatic test_commit_swap();
        logic [7:0] er, ec;
        for (int r = 0; r < 8; r++) begin
            wr_valid = 1'b1; wr_row = r[2:0]; wr_data = 8'h80 >> r;
            tick();
        end
        wr_valid = 1'b0;
        vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL pre_commit_ready got %b expected 1", wr_ready); end
        commit = 1'b1;
        tick();
        commit = 1'b0;
        vectors++; if (commit_pending !== 1'b1) begin miscompares++; $display("[TB] FAIL commit_pending got %b expected 1", commit_pending); end
        vectors++; if (wr_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL commit_ready got %b expected 0", wr_ready); end
        goto_cycle(95);
        vectors++; if (commit_pending !== 1'b1) begin miscompares++; $display("[TB] FAIL pending_until_swap got %b expected 1", commit_pending); end
        vectors++; if (col_pins !== 8'hFF) begin miscompares++; $display("[TB] FAIL old_front_row7 got %h expected %h", col_pins, 8'hFF); end
        tick();
        vectors++; if (commit_pending !== 1'b0) begin miscompares++; $display("[TB] FAIL swap_pending got %b expected 0", commit_pending); end
        vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL swap_ready got %b expected 1", wr_ready); end
        for (int c = 0; c < 48; c++) begin
            er = ((c % 6) < 2) ? 8'h00 : (8'h80 >> (c / 6));
            ec = ((c % 6) < 2) ? 8'hFF : ~(8'h80 >> (c / 6));
            vectors++; if (row_pins !== er) begin miscompares++; $display("[TB] FAIL diag_row c=%0d got %h expected %h", c, row_pins, er); end
            vectors++; if (col_pins !== ec) begin miscompares++; $display("[TB] FAIL diag_col c=%0d got %h expected %h", c, col_pins, ec); end
            tick();
        end
    endtask

    task automatic test_commit_during_pending();
        logic [7:0] er, ec;
        for (int r = 0; r < 8; r++) begin
            wr_valid = 1'b1; wr_row = r[2:0]; wr_data = 8'h3C;
            tick();
        end
        wr_valid = 1'b0;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        vectors++; if (commit_pending !== 1'b1) begin miscompares++; $display("[TB] FAIL second_pending got %b expected 1", commit_pending); end
        goto_cycle(160);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        wr_valid = 1'b1; wr_row = 3'd3; wr_data = 8'hFF;
        tick();
        wr_valid = 1'b0;
        vectors++; if (wr_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL blocked_ready got %b expected 0", wr_ready); end
        goto_cycle(191);
        vectors++; if (commit_pending !== 1'b1) begin miscompares++; $display("[TB] FAIL pending_before_swap got %b expected 1", commit_pending); end
        tick();
        vectors++; if (commit_pending !== 1'b0) begin miscompares++; $display("[TB] FAIL no_extend_pending got %b expected 0", commit_pending); end
        for (int c = 0; c < 48; c++) begin
            er = ((c % 6) < 2) ? 8'h00 : (8'h80 >> (c / 6));
            ec = ((c % 6) < 2) ? 8'hFF : 8'hC3;
            vectors++; if (row_pins !== er) begin miscompares++; $display("[TB] FAIL fill_row c=%0d got %h expected %h", c, row_pins, er); end
            vectors++; if (col_pins !== ec) begin miscompares++; $display("[TB] FAIL fill_col c=%0d got %h expected %h", c, col_pins, ec); end
            tick();
        end
    endtask

    task automatic test_swap_race();
        logic [7:0] er;
        goto_cycle(287);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        vectors++; if (commit_pending !== 1'b1) begin miscompares++; $display("[TB] FAIL race_pending got %b expected 1", commit_pending); end
        vectors++; if (frame_start !== 1'b1) begin miscompares++; $display("[TB] FAIL race_frame_start got %b expected 1", frame_start); end
        goto_cycle(290);
        vectors++; if (col_pins !== 8'hC3) begin miscompares++; $display("[TB] FAIL race_no_swap_col got %h expected %h", col_pins, 8'hC3); end
        goto_cycle(335);
        vectors++; if (commit_pending !== 1'b1) begin miscompares++; $display("[TB] FAIL race_deferred got %b expected 1", commit_pending); end
        tick();
        vectors++; if (commit_pending !== 1'b0) begin miscompares++; $display("[TB] FAIL race_swap got %b expected 0", commit_pending); end
        for (int r = 0; r < 8; r++) begin
            goto_cycle(336 + 6 * r + 2);
            er = 8'h80 >> r;
            vectors++; if (row_pins !== er) begin miscompares++; $display("[TB] FAIL race_row r=%0d got %h expected %h", r, row_pins, er); end
            vectors++; if (col_pins !== ~er) begin miscompares++; $display("[TB] FAIL race_col r=%0d got %h expected %h", r, col_pins, ~er); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] er;
        goto_cycle(384);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        goto_cycle(417);
        vectors++; if (col_pins !== 8'hFB) begin miscompares++; $display("[TB] FAIL mid_row5_col got %h expected %h", col_pins, 8'hFB); end
        rst_n = 1'b0;
        tick();
        vectors++; if (row_pins !== 8'h00) begin miscompares++; $display("[TB] FAIL mid_reset_row got %h expected %h", row_pins, 8'h00); end
        vectors++; if (col_pins !== 8'hFF) begin miscompares++; $display("[TB] FAIL mid_reset_col got %h expected %h", col_pins, 8'hFF); end
        vectors++; if (commit_pending !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_reset_pending got %b expected 0", commit_pending); end
        tick();
        rst_n = 1'b1;
        cyc = -1;
        tick();
        commit = 1'b1;
        for (int c = 0; c < 48; c++) begin
            er = ((c % 6) < 2) ? 8'h00 : (8'h80 >> (c / 6));
            vectors++; if (row_pins !== er) begin miscompares++; $display("[TB] FAIL post_reset_row c=%0d got %h expected %h", c, row_pins, er); end
            vectors++; if (col_pins !== 8'hFF) begin miscompares++; $display("[TB] FAIL post_reset_col c=%0d got %h expected %h", c, col_pins, 8'hFF); end
            tick();
            commit = 1'b0;
        end
        vectors++; if (commit_pending !== 1'b0) begin miscompares++; $display("[TB] FAIL post_reset_swap got %b expected 0", commit_pending); end
        for (int r = 0; r < 8; r++) begin
            goto_cycle(48 + 6 * r + 2);
            vectors++; if (col_pins !== 8'hFF) begin miscompares++; $display("[TB] FAIL cleared_back r=%0d got %h expected %h", r, col_pins, 8'hFF); end
        end
    endtask

    task automatic test_polarity();
        p_rst_n = 1'b1;
        cyc = -1;
        tick();
        vectors++; if (p_row_pins !== 8'hFF) begin miscompares++; $display("[TB] FAIL pol_blank_row got %h expected %h", p_row_pins, 8'hFF); end
        vectors++; if (p_col_pins !== 8'h00) begin miscompares++; $display("[TB] FAIL pol_blank_col got %h expected %h", p_col_pins, 8'h00); end
        vectors++; if (p_frame_start !== 1'b1) begin miscompares++; $display("[TB] FAIL pol_frame_start got %b expected 1", p_frame_start); end
        p_wr_valid = 1'b1; p_wr_row = 3'd0; p_wr_data = 8'hA5;
        tick();
        p_wr_valid = 1'b0;
        p_commit = 1'b1;
        tick();
        p_commit = 1'b0;
        vectors++; if (p_row_pins !== 8'h7F) begin miscompares++; $display("[TB] FAIL pol_pre_row got %h expected %h", p_row_pins, 8'h7F); end
        vectors++; if (p_col_pins !== 8'h00) begin miscompares++; $display("[TB] FAIL pol_pre_col got %h expected %h", p_col_pins, 8'h00); end
        goto_cycle(48);
        vectors++; if (p_row_pins !== 8'hFF) begin miscompares++; $display("[TB] FAIL pol_blank2_row got %h expected %h", p_row_pins, 8'hFF); end
        vectors++; if (p_col_pins !== 8'h00) begin miscompares++; $display("[TB] FAIL pol_blank2_col got %h expected %h", p_col_pins, 8'h00); end
        goto_cycle(50);
        vectors++; if (p_row_pins !== 8'h7F) begin miscompares++; $display("[TB] FAIL pol_drive_row got %h expected %h", p_row_pins, 8'h7F); end
        vectors++; if (p_col_pins !== 8'hA5) begin miscompares++; $display("[TB] FAIL pol_drive_col got %h expected %h", p_col_pins, 8'hA5); end
        goto_cycle(56);
        vectors++; if (p_row_pins !== 8'hBF) begin miscompares++; $display("[TB] FAIL pol_row1 got %h expected %h", p_row_pins, 8'hBF); end
        vectors++; if (p_col_pins !== 8'h00) begin miscompares++; $display("[TB] FAIL pol_row1_col got %h expected %h", p_col_pins, 8'h00); end
    endtask

    initial begin
        test_reset();
        test_scan_timing();
        test_commit_swap();
        test_commit_during_pending();
        test_swap_race();
        test_reset_mid();
        test_polarity();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
